// File: rtl/multicycle_ctrl_pkg.sv
// mc_defs: shared definitions for the multicycle controller and its datapath.
//   - opcode constants (IR[15:12])
//   - FSM state encoding (also exported on the debug state port)
//   - ALU operation codes
//   - ALU source-B select encoding, shared with the source-B operand mux
package mc_defs;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_ADDI  = 4'h1;
  localparam logic [3:0] OP_ORI   = 4'h2;
  localparam logic [3:0] OP_LW    = 4'h3;
  localparam logic [3:0] OP_SW    = 4'h4;
  localparam logic [3:0] OP_BEQ   = 4'h5;
  localparam logic [3:0] OP_JMP   = 4'h6;
  localparam logic [3:0] OP_LUI   = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_EXEC_R   = 4'd2,
    S_EXEC_I   = 4'd3,
    S_MEM_ADDR = 4'd4,
    S_MEM_RD   = 4'd5,
    S_MEM_WB   = 4'd6,
    S_MEM_WR   = 4'd7,
    S_ALU_WB   = 4'd8,
    S_BRANCH   = 4'd9,
    S_JUMP     = 4'd10,
    S_HALT     = 4'd11
  } state_t;

  typedef enum logic [2:0] {
    ALU_ADD   = 3'd0,
    ALU_SUB   = 3'd1,
    ALU_AND   = 3'd2,
    ALU_OR    = 3'd3,
    ALU_PASSB = 3'd4,
    ALU_F5    = 3'd5,
    ALU_F6    = 3'd6,
    ALU_F7    = 3'd7
  } alu_op_t;

  typedef enum logic [2:0] {
    SRCB_B          = 3'd0,  // register B
    SRCB_TWO        = 3'd1,  // constant 2 (PC increment)
    SRCB_SEXT       = 3'd2,
    SRCB_ZEXT       = 3'd3,
    SRCB_SEXT_SHL_L = 3'd4,  // long sign-extended, shifted left 1 (branch offset)
    SRCB_SEXT_L     = 3'd5,
    SRCB_ZEXT_L     = 3'd6,
    SRCB_ZERO       = 3'd7
  } srcb_sel_t;

  // R-type function field is laid out to match the ALU op codes directly.
  function automatic alu_op_t funct_to_alu_op(input logic [2:0] f);
    return alu_op_t'(f);
  endfunction

endpackage

// File: rtl/multicycle_ctrl_watchdog.sv
// mem_wait_watchdog: counts consecutive cycles the controller stalls on memory.
//   clk, rst   : clock, async active-high reset
//   wait_i     : FSM is in a memory-wait state and mem_ready is low this cycle
//   expired_o  : this stall cycle brings the count to MEM_WAIT_MAX
// Any non-waiting cycle (ready seen, or a state change) clears the count.
module mem_wait_watchdog #(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic wait_i,
  output logic expired_o
);

  localparam int W = $clog2(MEM_WAIT_MAX + 1);
  localparam logic [W-1:0] LAST = W'(MEM_WAIT_MAX - 1);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = wait_i ? cnt_q + 1'b1 : '0;
  end

  // Fires on the stall cycle whose increment reaches the limit, so the FSM
  // leaves for HALT on the same edge the count hits MEM_WAIT_MAX.
  assign expired_o = wait_i && (cnt_q == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore control FSM for the 16-bit multicycle datapath.
//   Inputs : opcode/funct from IR, ALU zero flag, mem_ready handshake.
//   Outputs: ALU source/op selects, PC/IR/memory/register strobes, address and
//            writeback selects, halted, sticky fault, debug state.
// All outputs decode from the state register except ir_write/pc_write in
// FETCH, which follow mem_ready. While rst is high every output reads 0.
module multicycle_ctrl
  import mc_defs::*;
#(
  parameter int MEM_WAIT_MAX = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] opcode,
  input  logic [2:0] funct,
  input  logic       zero,
  input  logic       mem_ready,
  output logic [2:0] alusrcb_sel,
  output logic       alusrca_sel,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       reg_write,
  output logic       i_or_d,
  output logic       mem_to_reg,
  output logic       reg_dst,
  output logic [1:0] pc_source,
  output logic       halted,
  output logic       fault,
  output logic [3:0] state
);

  state_t    state_q, state_d;
  logic      fault_q, fault_d;
  logic      waiting, wd_expired;
  alu_op_t   alu_op_c;
  srcb_sel_t srcb_c;

  // The branch decision (zero & pc_write_cond) is formed in the datapath.
  logic unused_zero;
  assign unused_zero = zero;

  assign waiting = !mem_ready &&
                   (state_q == S_FETCH || state_q == S_MEM_RD || state_q == S_MEM_WR);

  mem_wait_watchdog #(.MEM_WAIT_MAX(MEM_WAIT_MAX)) u_wd (
    .clk       (clk),
    .rst       (rst),
    .wait_i    (waiting),
    .expired_o (wd_expired)
  );

  // Next state
  always_comb begin
    state_d = state_q;
    fault_d = fault_q;
    case (state_q)
      S_FETCH:    if (mem_ready) state_d = S_DECODE;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE:                  state_d = S_EXEC_R;
          OP_ADDI, OP_ORI, OP_LUI:   state_d = S_EXEC_I;
          OP_LW, OP_SW:              state_d = S_MEM_ADDR;
          OP_BEQ:                    state_d = S_BRANCH;
          OP_JMP:                    state_d = S_JUMP;
          OP_HALT:                   state_d = S_HALT;
          default: begin
            state_d = S_HALT;
            fault_d = 1'b1;
          end
        endcase
      end
      S_EXEC_R, S_EXEC_I: state_d = S_ALU_WB;
      S_MEM_ADDR: state_d = (opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   if (mem_ready) state_d = S_MEM_WB;
      S_MEM_WR:   if (mem_ready) state_d = S_FETCH;
      S_MEM_WB, S_ALU_WB, S_BRANCH, S_JUMP: state_d = S_FETCH;
      S_HALT:     state_d = S_HALT;
      default: begin
        state_d = S_HALT;
        fault_d = 1'b1;
      end
    endcase
    // wd_expired implies mem_ready is low, so a completing access always wins.
    if (wd_expired) begin
      state_d = S_HALT;
      fault_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_FETCH;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      fault_q <= fault_d;
    end
  end

  // Output decode
  always_comb begin
    srcb_c        = SRCB_B;
    alu_op_c      = ALU_ADD;
    alusrca_sel   = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    ir_write      = 1'b0;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    reg_write     = 1'b0;
    i_or_d        = 1'b0;
    mem_to_reg    = 1'b0;
    reg_dst       = 1'b0;
    pc_source     = 2'd0;
    case (state_q)
      S_FETCH: begin
        mem_read = 1'b1;
        srcb_c   = SRCB_TWO;
        ir_write = mem_ready;
        pc_write = mem_ready;
      end
      S_DECODE: srcb_c = SRCB_SEXT_SHL_L;
      S_EXEC_R: begin
        alusrca_sel = 1'b1;
        alu_op_c    = funct_to_alu_op(funct);
      end
      S_EXEC_I: begin
        alusrca_sel = 1'b1;
        case (opcode)
          OP_ORI:  begin srcb_c = SRCB_ZEXT;   alu_op_c = ALU_OR;    end
          OP_LUI:  begin srcb_c = SRCB_ZEXT_L; alu_op_c = ALU_PASSB; end
          default: begin srcb_c = SRCB_SEXT;   alu_op_c = ALU_ADD;   end
        endcase
      end
      S_ALU_WB: begin
        reg_write = 1'b1;
        reg_dst   = (opcode == OP_RTYPE);
      end
      S_MEM_ADDR: begin
        alusrca_sel = 1'b1;
        srcb_c      = SRCB_SEXT_L;
      end
      S_MEM_RD: begin
        mem_read = 1'b1;
        i_or_d   = 1'b1;
      end
      S_MEM_WB: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      S_MEM_WR: begin
        mem_write = 1'b1;
        i_or_d    = 1'b1;
      end
      S_BRANCH: begin
        alusrca_sel   = 1'b1;
        alu_op_c      = ALU_SUB;
        pc_write_cond = 1'b1;
        pc_source     = 2'd1;
      end
      S_JUMP: begin
        pc_write  = 1'b1;
        pc_source = 2'd2;
      end
      default: ;
    endcase
    // Reset aborts mid-instruction without letting any strobe escape.
    if (rst) begin
      srcb_c        = SRCB_B;
      alu_op_c      = ALU_ADD;
      alusrca_sel   = 1'b0;
      pc_write      = 1'b0;
      pc_write_cond = 1'b0;
      ir_write      = 1'b0;
      mem_read      = 1'b0;
      mem_write     = 1'b0;
      reg_write     = 1'b0;
      i_or_d        = 1'b0;
      mem_to_reg    = 1'b0;
      reg_dst       = 1'b0;
      pc_source     = 2'd0;
    end
  end

  assign alusrcb_sel = srcb_c;
  assign alu_op      = alu_op_c;
  assign halted      = (state_q == S_HALT);
  assign fault       = fault_q;
  assign state       = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench for multicycle_ctrl. Each instruction is expanded into
// the list of per-cycle output expectations it should produce, then driven
// with randomized memory stalls; latency is also checked against the
// per-opcode cycle counts.
module tb_multicycle_ctrl;
  import mc_defs::*;

  logic       clk, rst;
  logic [3:0] opcode;
  logic [2:0] funct;
  logic       zero, mem_ready;
  logic [2:0] alusrcb_sel, alu_op;
  logic       alusrca_sel, pc_write, pc_write_cond, ir_write, mem_read, mem_write;
  logic       reg_write, i_or_d, mem_to_reg, reg_dst, halted, fault;
  logic [1:0] pc_source;
  logic [3:0] state;

  multicycle_ctrl #(.MEM_WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .funct(funct), .zero(zero),
    .mem_ready(mem_ready), .alusrcb_sel(alusrcb_sel), .alusrca_sel(alusrca_sel),
    .alu_op(alu_op), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .ir_write(ir_write), .mem_read(mem_read), .mem_write(mem_write),
    .reg_write(reg_write), .i_or_d(i_or_d), .mem_to_reg(mem_to_reg),
    .reg_dst(reg_dst), .pc_source(pc_source), .halted(halted), .fault(fault),
    .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0] srcb;
    logic       srca;
    logic [2:0] aluop;
    logic       pcw, pcwc, irw, mrd, mwr, rw, iord, m2r, rdst;
    logic [1:0] pcsrc;
    logic       hlt, flt;
  } exp_t;

  exp_t obs;
  assign obs = {alusrcb_sel, alusrca_sel, alu_op, pc_write, pc_write_cond, ir_write,
                mem_read, mem_write, reg_write, i_or_d, mem_to_reg, reg_dst,
                pc_source, halted, fault};

  int total = 0;
  int bad   = 0;

  exp_t ph [0:5];
  bit   ph_wait [0:5];
  int   nph;

  task automatic check(input exp_t e, input string tag);
    zero = 1'($urandom);
    #1;
    total++;
    assert (obs === e) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, e);
    end
  endtask

  task automatic check_int(input int o, input int e, input string tag);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, o, e);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  function automatic exp_t halt_exp(input logic f);
    exp_t e = '0;
    e.hlt = 1'b1;
    e.flt = f;
    return e;
  endfunction

  // Expected output cycles for one instruction, straight from the op table.
  task automatic build(input logic [3:0] op, input logic [2:0] fn);
    exp_t e;
    for (int i = 0; i < 6; i++) begin ph[i] = '0; ph_wait[i] = 1'b0; end
    ph[0].mrd = 1'b1; ph[0].srcb = 3'd1; ph_wait[0] = 1'b1;   // fetch
    ph[1].srcb = 3'd4;                                        // decode
    nph = 2;
    e = '0;
    case (op)
      4'h0, 4'h1, 4'h2, 4'h7: begin
        e.srca = 1'b1;
        case (op)
          4'h0:    begin e.srcb = 3'd0; e.aluop = fn;   end
          4'h1:    begin e.srcb = 3'd2; e.aluop = 3'd0; end
          4'h2:    begin e.srcb = 3'd3; e.aluop = 3'd3; end
          default: begin e.srcb = 3'd6; e.aluop = 3'd4; end
        endcase
        ph[2] = e;
        e = '0; e.rw = 1'b1; e.rdst = (op == 4'h0);
        ph[3] = e; nph = 4;
      end
      4'h3, 4'h4: begin
        e.srca = 1'b1; e.srcb = 3'd5;
        ph[2] = e;
        e = '0; e.iord = 1'b1;
        if (op == 4'h3) e.mrd = 1'b1; else e.mwr = 1'b1;
        ph[3] = e; ph_wait[3] = 1'b1;
        nph = 4;
        if (op == 4'h3) begin
          e = '0; e.rw = 1'b1; e.m2r = 1'b1;
          ph[4] = e; nph = 5;
        end
      end
      4'h5: begin
        e.srca = 1'b1; e.aluop = 3'd1; e.pcwc = 1'b1; e.pcsrc = 2'd1;
        ph[2] = e; nph = 3;
      end
      4'h6: begin
        e.pcw = 1'b1; e.pcsrc = 2'd2;
        ph[2] = e; nph = 3;
      end
      default: ;
    endcase
  endtask

  function automatic int base_latency(input logic [3:0] op);
    case (op)
      4'h3:       return 5;
      4'h5, 4'h6: return 3;
      default:    return 4;
    endcase
  endfunction

  task automatic do_reset(input string tag);
    rst = 1'b1;
    #1;
    check('0, {tag, "_outs"});
    check_int(int'(state), int'(S_FETCH), {tag, "_state"});
    tick();
    rst = 1'b0;
  endtask

  // fw / mw: stall cycles in fetch / memory phase. abort_ph >= 0 pulses reset
  // after the first stall cycle of that phase.
  task automatic run_instr(input logic [3:0] op, input logic [2:0] fn,
                           input int fw, input int mw, input int abort_ph, input string tag);
    int   cyc, w;
    exp_t e;
    cyc = 0;
    opcode = op; funct = fn;
    build(op, fn);
    for (int p = 0; p < nph; p++) begin
      if (ph_wait[p]) begin
        w = (p == 0) ? fw : mw;
        for (int k = 0; k < w; k++) begin
          mem_ready = 1'b0;
          check(ph[p], $sformatf("%s_ph%0d_wait%0d", tag, p, k));
          if (p == abort_ph) begin
            do_reset({tag, "_abort"});
            return;
          end
          tick(); cyc++;
        end
        mem_ready = 1'b1;
        e = ph[p];
        if (p == 0) begin e.irw = 1'b1; e.pcw = 1'b1; end
        check(e, $sformatf("%s_ph%0d", tag, p));
      end else begin
        mem_ready = 1'($urandom);
        check(ph[p], $sformatf("%s_ph%0d", tag, p));
      end
      tick(); cyc++;
    end
    if (op <= 4'h7)
      check_int(cyc, base_latency(op) + fw + mw, {tag, "_latency"});
  endtask

  logic [3:0] rop;
  int         rmw;

  initial begin
    rst = 1'b1; mem_ready = 1'b0; opcode = 4'h0; funct = 3'd0; zero = 1'b0;
    tick();
    check('0, "reset_outs");
    check_int(int'(state), int'(S_FETCH), "reset_state");
    tick();
    rst = 1'b0;

    // Ready arrives on the 15th stall cycle: no fault, instruction proceeds.
    run_instr(4'h6, 3'd0, 14, 0, -1, "wd_ready_edge");

    run_instr(4'h0, 3'd0, 0, 0, -1, "add_r");
    run_instr(4'h3, 3'd0, 0, 3, -1, "lw_wait3");
    zero = 1'b1;
    run_instr(4'h5, 3'd0, 0, 0, -1, "beq_z1");
    run_instr(4'h5, 3'd0, 0, 0, -1, "beq_z0");
    run_instr(4'h4, 3'd0, 1, 2, -1, "sw");
    run_instr(4'h7, 3'd0, 0, 0, -1, "lui");

    for (int i = 0; i < 40; i++) begin
      rop = 4'($urandom_range(0, 7));
      rmw = (rop == 4'h3 || rop == 4'h4) ? int'($urandom_range(0, 4)) : 0;
      run_instr(rop, 3'($urandom), int'($urandom_range(0, 4)), rmw, -1,
                $sformatf("rnd%0d_op%0d", i, rop));
    end

    // Reset during LW's memory read.
    run_instr(4'h3, 3'd0, 0, 2, 3, "lw_rst");
    run_instr(4'h1, 3'd5, 0, 0, -1, "after_rst_addi");

    // Illegal opcode: fault + halt, quiet thereafter.
    run_instr(4'h9, 3'd0, 0, 0, -1, "illegal");
    for (int k = 0; k < 20; k++) begin
      mem_ready = 1'($urandom);
      check(halt_exp(1'b1), $sformatf("illegal_halt%0d", k));
      tick();
    end
    do_reset("clr_fault");

    // Legal HALT opcode: halted without fault.
    run_instr(4'hF, 3'd0, 0, 0, -1, "halt_op");
    mem_ready = 1'b1;
    check(halt_exp(1'b0), "halt_op_state");
    tick();
    do_reset("clr_halt");

    // Fetch watchdog expiry.
    opcode = 4'h0;
    build(4'h0, 3'd0);
    for (int k = 0; k < 15; k++) begin
      mem_ready = 1'b0;
      check(ph[0], $sformatf("wd_fetch%0d", k));
      tick();
    end
    mem_ready = 1'b0;
    check(halt_exp(1'b1), "wd_expired");
    check_int(int'(state), int'(S_HALT), "wd_state");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Moore-style control FSM for the 16-bit multicycle datapath.
- Sequences fetch, decode, execute, memory and writeback for each instruction.
- Drives every datapath select and write strobe, including the 3-bit ALU source-B select consumed by the source-B operand mux.
- Sits between the instruction register (opcode, function field) and the datapath, and handshakes with unified memory through a ready input.

## Interface
Parameters:
- MEM_WAIT_MAX, 15: watchdog limit on consecutive cycles waiting for mem_ready; exceeding it asserts fault.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous, active-high reset
- opcode  in  4  IR[15:12]
- funct  in  3  IR[2:0], R-type ALU function
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- alusrcb_sel  out  3  source-B select: 0 B, 1 constant 2, 2 signext, 3 zeroext, 4 signext<<1 long, 5 signext long, 6 zeroext long, 7 zero
- alusrca_sel  out  1  0 PC, 1 A
- alu_op  out  3  0 ADD, 1 SUB, 2 AND, 3 OR, 4 pass B, 5..7 pass funct mapping
- pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write  out  1 each  strobes
- i_or_d  out  1  memory address: 0 PC, 1 ALUOut
- mem_to_reg  out  1  writeback source: 0 ALUOut, 1 MDR
- reg_dst  out  1  0 IR[8:6], 1 IR[5:3]
- pc_source  out  2  0 ALU result, 1 ALUOut, 2 jump target
- halted  out  1  in HALT state
- fault  out  1  sticky; illegal opcode or memory watchdog expiry
- state  out  4  current state, for debug

## Operation
- Opcodes: 0 RTYPE, 1 ADDI, 2 ORI, 3 LW, 4 SW, 5 BEQ, 6 JMP, 7 LUI, F HALT. Opcodes 8–E are illegal.
- States: FETCH, DECODE, EXEC_R, EXEC_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, ALU_WB, BRANCH, JUMP, HALT.
- FETCH:
  - Outputs: mem_read=1, i_or_d=0, alusrca=0, alusrcb=1, alu_op=ADD, pc_source=0.
  - ir_write and pc_write = mem_ready; these are the only Mealy outputs.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE:
  - Outputs: alusrca=0, alusrcb=4, ADD; precomputes the branch target into ALUOut.
  - Next state: RTYPE→EXEC_R; ADDI/ORI/LUI→EXEC_I; LW/SW→MEM_ADDR; BEQ→BRANCH; JMP→JUMP; HALT→HALT.
  - An illegal opcode sets fault and goes to HALT.
- EXEC_R: alusrca=1, alusrcb=0, alu_op from funct; then ALU_WB.
- EXEC_I: alusrca=1, ADD or OR. alusrcb is 2 for ADDI, 3 for ORI, and 6 for LUI (with alu_op=pass B). Then ALU_WB.
- ALU_WB: reg_write=1, mem_to_reg=0. reg_dst is 1 for RTYPE, 0 otherwise. Then FETCH.
- MEM_ADDR: alusrca=1, alusrcb=5, ADD. LW→MEM_RD; SW→MEM_WR.
- MEM_RD: mem_read=1, i_or_d=1. Held until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; then FETCH.
- MEM_WR: mem_write=1, i_or_d=1. Held until mem_ready, then FETCH.
- BRANCH: alusrca=1, alusrcb=0, SUB, pc_write_cond=1, pc_source=1; then FETCH.
- JUMP: pc_write=1, pc_source=2; then FETCH.
- HALT: absorbing; all strobes 0; only rst exits.
- Opcode and funct are sampled combinationally from IR. IR is stable after FETCH completes.
- Watchdog:
  - A counter increments each cycle the FSM waits for mem_ready in FETCH, MEM_RD or MEM_WR, and clears on state change.
  - When the count reaches MEM_WAIT_MAX: fault=1, next state HALT.
  - mem_ready in the same cycle takes priority over the watchdog.
- Unlisted outputs are 0 in every state.

## Timing
- Reset:
  - state=FETCH, watchdog=0, fault=0, halted=0.
  - While rst=1, all strobes (pc_write, pc_write_cond, ir_write, mem_read, mem_write, reg_write) are forced to 0 and all selects read 0.
- Reset mid-instruction aborts immediately with no write strobe escaping; FETCH begins on the first edge after deassertion.
- Latency with mem_ready=1 throughout:
  - RTYPE, ADDI, ORI, LUI, SW: 4 cycles.
  - LW: 5 cycles.
  - BEQ, JMP: 3 cycles.
- Each wait cycle adds 1.
- Outputs are valid from the state register (clock-to-out). The exception is ir_write/pc_write in FETCH, which depend combinationally on mem_ready.

## Structure
- Shared package `mc_defs` holds:
  - opcode constants;
  - state encoding;
  - alu_op codes;
  - the ALU source-B select encoding (0–7 above), shared with the source-B mux so both ends agree.
- One sub-module, `mem_wait_watchdog`: counter, clear, limit compare, and expired output.
- The FSM has a separate next-state block and output-decode block.

## Test plan
- Reset during MEM_RD of LW (rst pulsed 1 cycle) → state=FETCH, mem_read forced 0 while rst=1, no reg_write.
- ADD R-type (opcode 0, funct 0) with mem_ready=1 → FETCH, DECODE, EXEC_R, ALU_WB. alusrcb is 1,4,0 in the first three states; reg_write=1 only in cycle 4, reg_dst=1.
- LW with mem_ready low 3 cycles in MEM_RD → total 8 cycles; alusrcb=5 in MEM_ADDR; mem_to_reg=1 in MEM_WB.
- BEQ, zero=1 and zero=0 → 3 cycles; pc_write_cond=1, pc_source=1, alusrcb=0 in BRANCH.
- Opcode 0x9 → fault=1 and halted=1 after DECODE; all strobes stay 0 for 20 further cycles.
- mem_ready held 0 in FETCH → fault set on the cycle the count reaches 15, then HALT. Repeat with mem_ready rising on that same cycle → DECODE, no fault.
